sdram_call_scheduler: RTL and testbench

- Top-level sequencer for the SDRAM module.
- Owns the single SDRAM command engine (init, auto-refresh, write, read sub-functions) and calls exactly one sub-function at a time.
- Arbitrates between two user requesters (write, read) and an internal periodic refresh timer; returns per-requester completion pulses.
- Sits between the user-side FIFO/readout logic and the SDRAM sub-function modules.

---
 rtl/sdram_sched_pkg.sv | 21 ++
 rtl/sdram_ref_timer.sv | 55 +++++
 rtl/sdram_call_scheduler.sv | 145 ++++++++++++++
 tb/tb_sdram_call_scheduler.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/sdram_sched_pkg.sv
// Shared types and index constants for the SDRAM call scheduler and its refresh timer.
package sdram_sched_pkg;

    typedef enum logic [2:0] {
        S_INIT      = 3'd0,
        S_INIT_WAIT = 3'd1,
        S_IDLE      = 3'd2,
        S_REF       = 3'd3,
        S_WR        = 3'd4,
        S_RD        = 3'd5
    } state_e;

    localparam int CALL_INIT = 0;
    localparam int CALL_REF  = 1;
    localparam int CALL_WR   = 2;
    localparam int CALL_RD   = 3;

    localparam int REQ_WR = 0;
    localparam int REQ_RD = 1;

endpackage

// File: rtl/sdram_ref_timer.sv
// Free-running refresh interval timer with pending and sticky late flags.
module sdram_ref_timer #(
    parameter int REF_INTERVAL = 780
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run_i,
    input  logic clr_i,
    output logic pend_o,
    output logic late_o
);

    localparam int CW = $clog2(REF_INTERVAL);
    localparam logic [CW-1:0] LAST = CW'(REF_INTERVAL - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          pend_q, pend_d;
    logic          late_q, late_d;
    logic          expire;

    always_comb begin
        expire = run_i && (cnt_q == LAST);
        cnt_d  = cnt_q;
        pend_d = pend_q;
        late_d = late_q;
        if (run_i) begin
            cnt_d = expire ? '0 : cnt_q + 1'b1;
        end
        // A new expiry wins over the clear, so a same-cycle issue leaves a fresh request
        if (expire) begin
            pend_d = 1'b1;
            if (pend_q && !clr_i) begin
                late_d = 1'b1;
            end
        end else if (clr_i) begin
            pend_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            pend_q <= 1'b0;
            late_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            pend_q <= pend_d;
            late_q <= late_d;
        end
    end

    assign pend_o = pend_q;
    assign late_o = late_q;

endmodule

// File: rtl/sdram_call_scheduler.sv
// SDRAM top-level sequencer: init, refresh and round-robin write/read calls to one command engine.
// Define SDRAM_SCHED_TIMEOUT_EN to add a per-call watchdog and the sticky oTimeout output.
module sdram_call_scheduler
    import sdram_sched_pkg::*;
#(
    parameter int REF_INTERVAL = 780
`ifdef SDRAM_SCHED_TIMEOUT_EN
    , parameter int TIMEOUT_CYC = 4096
`endif
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] iCall,
    input  logic       iDone,
    output logic [1:0] oDone,
    output logic [3:0] oCall,
    output logic       oRefLate,
    output logic       oBusy
`ifdef SDRAM_SCHED_TIMEOUT_EN
    , output logic     oTimeout
`endif
);

    state_e     state_q, state_d;
    logic [3:0] call_q, call_d;
    logic [1:0] done_q, done_d;
    logic       busy_q, busy_d;
    logic       rr_q, rr_d;
    logic       ref_pend, ref_clr, timer_run, call_end;

    assign timer_run = (state_q != S_INIT) && (state_q != S_INIT_WAIT);

    sdram_ref_timer #(.REF_INTERVAL(REF_INTERVAL)) u_ref_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .run_i  (timer_run),
        .clr_i  (ref_clr),
        .pend_o (ref_pend),
        .late_o (oRefLate)
    );

`ifdef SDRAM_SCHED_TIMEOUT_EN
    localparam int WW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [WW-1:0] WD_LAST = WW'(TIMEOUT_CYC - 1);

    logic [WW-1:0] wd_q, wd_d;
    logic          tmo_q, tmo_d;
    logic          call_active, wd_expire;

    // Counter is zero whenever no call is outstanding, so each new call starts from zero
    always_comb begin
        call_active = (state_q == S_INIT_WAIT) || (state_q == S_REF) ||
                      (state_q == S_WR) || (state_q == S_RD);
        wd_expire   = call_active && !iDone && (wd_q == WD_LAST);
        wd_d        = call_active ? wd_q + 1'b1 : '0;
        tmo_d       = tmo_q | wd_expire;
        call_end    = iDone | wd_expire;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_q  <= '0;
            tmo_q <= 1'b0;
        end else begin
            wd_q  <= wd_d;
            tmo_q <= tmo_d;
        end
    end

    assign oTimeout = tmo_q;
`else
    assign call_end = iDone;
`endif

    always_comb begin
        state_d = state_q;
        call_d  = call_q;
        done_d  = '0;
        rr_d    = rr_q;
        ref_clr = 1'b0;
        unique case (state_q)
            S_INIT: begin
                call_d            = '0;
                call_d[CALL_INIT] = 1'b1;
                state_d           = S_INIT_WAIT;
            end
            S_INIT_WAIT: begin
                if (call_end) begin
                    call_d  = '0;
                    state_d = iDone ? S_IDLE : S_INIT;
                end
            end
            S_IDLE: begin
                call_d = '0;
                if (ref_pend) begin
                    call_d[CALL_REF] = 1'b1;
                    ref_clr          = 1'b1;
                    state_d          = S_REF;
                end else if (iCall[REQ_WR] && (!iCall[REQ_RD] || !rr_q)) begin
                    call_d[CALL_WR] = 1'b1;
                    rr_d            = 1'b1;
                    state_d         = S_WR;
                end else if (iCall[REQ_RD]) begin
                    call_d[CALL_RD] = 1'b1;
                    rr_d            = 1'b0;
                    state_d         = S_RD;
                end
            end
            S_REF, S_WR, S_RD: begin
                if (call_end) begin
                    call_d         = '0;
                    state_d        = S_IDLE;
                    done_d[REQ_WR] = (state_q == S_WR);
                    done_d[REQ_RD] = (state_q == S_RD);
                end
            end
            default: begin
                call_d  = '0;
                state_d = S_INIT;
            end
        endcase
        busy_d = (call_d != '0) || (state_d == S_INIT) || (state_d == S_INIT_WAIT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_INIT;
            call_q  <= '0;
            done_q  <= '0;
            busy_q  <= 1'b1;
            rr_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            call_q  <= call_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
            rr_q    <= rr_d;
        end
    end

    assign oCall = call_q;
    assign oDone = done_q;
    assign oBusy = busy_q;

endmodule

// File: tb/tb_sdram_call_scheduler.sv
// Scoreboard bench for sdram_call_scheduler: expected call/done events with cycle stamps.
`timescale 1ns/1ps
module tb_sdram_call_scheduler;

    localparam int REF_N = 32;
    localparam int TMO_N = 32;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b1;
    logic [1:0] iCall = 2'b00;
    logic       iDone = 1'b0;
    logic [1:0] oDone;
    logic [3:0] oCall;
    logic       oRefLate, oBusy;
`ifdef SDRAM_SCHED_TIMEOUT_EN
    logic       oTimeout;
`endif

    int cyc    = 0;
    int checks = 0;
    int errors = 0;

    // kind: 0 call rise, 1 call fall, 2 done pulse, 3 illegal call-to-call switch
    typedef struct {
        int         kind;
        logic [3:0] val;
        int         at;
    } ev_t;
    ev_t exp_q[$];

    sdram_call_scheduler #(
        .REF_INTERVAL(REF_N)
`ifdef SDRAM_SCHED_TIMEOUT_EN
        , .TIMEOUT_CYC(TMO_N)
`endif
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .iCall    (iCall),
        .iDone    (iDone),
        .oDone    (oDone),
        .oCall    (oCall),
        .oRefLate (oRefLate),
        .oBusy    (oBusy)
`ifdef SDRAM_SCHED_TIMEOUT_EN
        , .oTimeout (oTimeout)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic push(input int kind, input logic [3:0] val, input int at);
        ev_t e;
        e.kind = kind;
        e.val  = val;
        e.at   = at;
        exp_q.push_back(e);
    endtask

    task automatic sb_event(input int kind, input logic [3:0] val);
        ev_t e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL sb_unexpected: got kind=%0d val=%b at cycle %0d, expected no event", kind, val, cyc);
        end else begin
            e = exp_q.pop_front();
            if (kind != e.kind || val !== e.val || cyc != e.at) begin
                errors++;
                $display("FAIL sb_event: got kind=%0d val=%b cycle=%0d, expected kind=%0d val=%b cycle=%0d",
                         kind, val, cyc, e.kind, e.val, e.at);
            end
        end
    endtask

    // Monitor: samples on the falling edge, away from the active edge
    logic [3:0] prev_call = 4'b0000;
    always @(negedge clk) begin
        if (oCall != prev_call) begin
            if (prev_call == 4'b0000)  sb_event(0, oCall);
            else if (oCall == 4'b0000) sb_event(1, prev_call);
            else                       sb_event(3, oCall);
        end
        if (oDone != 2'b00) sb_event(2, {2'b00, oDone});
        prev_call <= oCall;
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) step(1);
    endtask

    task automatic expect_op(input logic [3:0] call, input int rise, input int hold, input logic [1:0] done);
        push(0, call, rise);
        push(1, call, rise + hold);
        if (done != 2'b00) push(2, {2'b00, done}, rise + hold);
    endtask

    // iDone is sampled at edge e
    task automatic ack_at(input int e);
        wait_until(e - 1);
        iDone = 1'b1;
        step(1);
        iDone = 1'b0;
    endtask

    task automatic reset_init(input int hold, output int d);
        int e0;
        iCall = 2'b00;
        iDone = 1'b0;
        rst_n = 1'b0;
        step(2);
        check("rst_oCall", {28'd0, oCall}, 32'h0);
        check("rst_oDone", {30'd0, oDone}, 32'h0);
        check("rst_oBusy", {31'd0, oBusy}, 32'h1);
        check("rst_oRefLate", {31'd0, oRefLate}, 32'h0);
        rst_n = 1'b1;
        e0 = cyc;
        expect_op(4'b0001, e0 + 1, hold, 2'b00);
        wait_until(e0 + 2);
        check("init_busy", {31'd0, oBusy}, 32'h1);
        ack_at(e0 + 1 + hold);
        d = cyc;
    endtask

    initial begin
        repeat (20000) @(posedge clk);
        $display("FAIL bench_timeout: got no finish within 20000 cycles, expected completion");
        $fatal(1, "bench timeout");
    end

    initial begin
        int d, c;

        // Init with a 20-cycle acknowledge, then a stray iDone while idle
        reset_init(20, d);
        check("init_done_busy", {31'd0, oBusy}, 32'h0);
        step(2);
        iDone = 1'b1;
        step(1);
        iDone = 1'b0;
        step(2);
        check("idle_iDone_busy", {31'd0, oBusy}, 32'h0);

        // Single write, acknowledged 5 cycles after the call rises
        c = cyc;
        iCall = 2'b01;
        expect_op(4'b0100, c + 1, 5, 2'b01);
        step(2);
        check("wr_busy", {31'd0, oBusy}, 32'h1);
        check("wr_call", {28'd0, oCall}, 32'h4);
        ack_at(c + 6);
        iCall = 2'b00;
        step(2);
        check("wr_after_busy", {31'd0, oBusy}, 32'h0);

        // Both requesters held: grants alternate starting with write
        reset_init(3, d);
        iCall = 2'b11;
        expect_op(4'b0100, d + 1,  3, 2'b01);
        expect_op(4'b1000, d + 5,  3, 2'b10);
        expect_op(4'b0100, d + 9,  3, 2'b01);
        expect_op(4'b1000, d + 13, 3, 2'b10);
        ack_at(d + 4);
        ack_at(d + 8);
        ack_at(d + 12);
        ack_at(d + 16);
        iCall = 2'b00;
        step(2);

        // Idle refresh cadence: one call per interval
        reset_init(3, d);
        for (int k = 1; k <= 3; k++) begin
            expect_op(4'b0010, d + k * REF_N + 1, 2, 2'b00);
            ack_at(d + k * REF_N + 3);
        end
        check("ref_no_late", {31'd0, oRefLate}, 32'h0);

        // Long write misses two expiries; refresh goes before the queued read
        reset_init(3, d);
        iCall = 2'b01;
        expect_op(4'b0100, d + 1, 2 * REF_N + 4, 2'b01);
        step(1);
        iCall = 2'b11;
        wait_until(d + 2 * REF_N - 1);
        check("late_before", {31'd0, oRefLate}, 32'h0);
        wait_until(d + 2 * REF_N);
        check("late_set", {31'd0, oRefLate}, 32'h1);
        ack_at(d + 2 * REF_N + 5);
        iCall = 2'b10;
        expect_op(4'b0010, d + 2 * REF_N + 6, 2, 2'b00);
        ack_at(d + 2 * REF_N + 8);
        expect_op(4'b1000, d + 2 * REF_N + 9, 2, 2'b10);
        step(1);
        iCall = 2'b00;
        ack_at(d + 2 * REF_N + 11);
        step(2);
        check("late_sticky", {31'd0, oRefLate}, 32'h1);

`ifdef SDRAM_SCHED_TIMEOUT_EN
        // Read never acknowledged: watchdog drops the call and still pulses oDone
        reset_init(3, d);
        iCall = 2'b10;
        expect_op(4'b1000, d + 1, TMO_N, 2'b10);
        wait_until(d + 20);
        check("tmo_before", {31'd0, oTimeout}, 32'h0);
        wait_until(d + 1 + TMO_N);
        iCall = 2'b00;
        check("tmo_set", {31'd0, oTimeout}, 32'h1);
        expect_op(4'b0010, d + TMO_N + 2, 2, 2'b00);
        ack_at(d + TMO_N + 4);
        step(2);
`endif

        reset_init(3, d);
        step(3);
        check("sb_queue_empty", exp_q.size(), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
